adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand/sum width in bits; legal values 1..64.
REQ-002 Port: clk  input  1  system clock; registered outputs update on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high; clears registered outputs only.
REQ-004 Port: A  input  WIDTH  operand A, unsigned.
REQ-005 Port: B  input  WIDTH  operand B, unsigned.
REQ-006 Port: ci  input  1  carry-in.
REQ-007 Port: out  output  WIDTH  combinational sum, low WIDTH bits of A+B+ci.
REQ-008 Port: co  output  1  combinational carry-out, bit WIDTH of A+B+ci.
REQ-009 Port: out_q  output  WIDTH  registered copy of out.
REQ-010 Port: co_q  output  1  registered copy of co.
REQ-011 Port: ovf  output  1  combinational signed overflow; operands read as two's complement.

Function
REQ-012 {co,out} SHALL equal the zero-extended (WIDTH+1)-bit value A+B+ci for every input combination.
REQ-013 out/co SHALL be purely combinational, zero clock latency, independent of clk and rst.
REQ-014 out/co SHALL settle within half a clk period after any A/B/ci change, so sampling on the next rising edge is valid.
REQ-015 Carry SHALL ripple LSB to MSB: stage i takes A[i], B[i], carry c[i] (c[0]=ci), produces out[i] and c[i+1]; co=c[WIDTH].
REQ-016 ovf SHALL equal c[WIDTH] XOR c[WIDTH-1]; for WIDTH=1, ovf = co XOR ci.
REQ-017 Wrap-around: results >= 2^WIDTH SHALL wrap in out and set co; no saturation.
REQ-018 out_q/co_q SHALL capture out/co on every rising clk edge while rst is low: one-cycle latency, no enable.
REQ-019 Simultaneous rst assertion and clk edge: reset SHALL win, registers hold 0.

Reset
REQ-020 rst high SHALL asynchronously force out_q=0 and co_q=0, without waiting for clk.
REQ-021 out, co and ovf SHALL remain functional during reset.
REQ-022 After rst deasserts, the first rising edge SHALL load the then-current out/co.

Structure
REQ-023 A one-bit full_adder sub-module SHALL be used (ports a, b, ci, s, co; s=a^b^ci, co=ab|ci(a^b)), instantiated WIDTH times by a generate loop.
REQ-024 No shared package is needed; WIDTH is the only constant and is passed by parameter.
REQ-025 The carry chain SHALL be explicit gates; the sum path SHALL NOT use a behavioural "+".

Verification (WIDTH=4, ci=0 unless stated)
REQ-026 A=0, B=0 -> out=0, co=0, ovf=0; next edge out_q=0, co_q=0.
REQ-027 A=15, B=1 -> out=0, co=1 (wrap); A=7, B=1 -> out=8, co=0, ovf=1.
REQ-028 A=15, B=15, ci=1 -> out=15, co=1; A=7, B=8 -> out=15, co=0, ovf=0.
REQ-029 16 random A/B pairs changed on falling edge, checked on rising edge -> {co,out} == A+B every time; bench reports count passed/total, fatal on any mismatch.
REQ-030 With out_q=9, assert rst between edges -> out_q=0, co_q=0 immediately while out still tracks A+B; deassert -> next edge loads out.

Source files
------------

// File: rtl/full_adder.sv
// Purpose: one-bit full adder cell used as a stage of the ripple-carry chain.
// Latency: purely combinational, no clock.
// Backpressure: none; the outputs follow the inputs continuously.
//
// Ports:
//   a, b : operand bits
//   ci   : carry into this stage
//   s    : sum bit, a ^ b ^ ci
//   co   : carry out of this stage, ab | ci(a ^ b)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;  // propagate term, shared by the sum and the carry

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder.sv
// Purpose: WIDTH-bit unsigned ripple-carry adder with carry-in, carry-out and signed overflow.
// Latency: out/co/ovf combinational (0 cycles); out_q/co_q registered (1 cycle).
// Backpressure: none; a new operand pair is accepted every cycle with no handshake.
//
// Ports:
//   clk   : clock; out_q/co_q update on the rising edge
//   rst   : asynchronous active-high reset; clears out_q/co_q only
//   A, B  : unsigned operands, WIDTH bits
//   ci    : carry-in
//   out   : low WIDTH bits of A+B+ci
//   co    : bit WIDTH of A+B+ci
//   out_q : out delayed by one clock
//   co_q  : co delayed by one clock
//   ovf   : two's-complement overflow of A+B+ci
module adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic [WIDTH-1:0] out_q,
  output logic             co_q,
  output logic             ovf
);

  // c[i] is the carry into stage i; c[0] is the external carry-in and
  // c[WIDTH] is the carry out of the MSB stage.
  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (out[i]),
      .co (c[i+1])
    );
  end

  assign co = c[WIDTH];

  // Signed overflow happens exactly when the carry into the sign bit differs
  // from the carry out of it. For WIDTH=1, c[WIDTH-1] is ci, so this also
  // covers the single-bit case.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  // Output register: no enable, reset has priority over a coincident edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      co_q  <= 1'b0;
    end else begin
      out_q <= out;
      co_q  <= co;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Purpose: self-checking bench for the ripple-carry adder at WIDTH=4.
// Latency: checks combinational outputs after settling and registered outputs one edge later.
// Backpressure: not applicable; operands are driven every cycle.
module tb_adder;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         co;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] A   = '0;
  logic [W-1:0] B   = '0;
  logic         ci  = 1'b0;
  logic [W-1:0] out;
  logic         co;
  logic [W-1:0] out_q;
  logic         co_q;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Registered-output scoreboard: pushed when operands are driven, popped
  // after the next rising edge.
  exp_t sb_q[$];

  adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .ci    (ci),
    .out   (out),
    .co    (co),
    .out_q (out_q),
    .co_q  (co_q),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timeout");
  end

  function automatic exp_t model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int   s;
    exp_t e;
    s     = int'(a) + int'(b) + int'(c);
    e.out = s[W-1:0];
    e.co  = s[W];
    return e;
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int sa;
    int sb;
    int s;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb + int'(c);
    return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
  endfunction

  // Pop one expected entry and compare the registered outputs, 1 time unit
  // after the rising edge.
  task automatic pop_and_check_reg(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at registered check", name);
    end else begin
      e = sb_q.pop_front();
      if ({co_q, out_q} !== {e.co, e.out}) begin
        errors++;
        $display("FAIL %s: {co_q,out_q} got %b_%h expected %b_%h", name, co_q, out_q, e.co, e.out);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({co_q, out_q} !== '0) begin
      errors++;
      $display("FAIL reset_async: {co_q,out_q} got %b_%h expected 0_0", co_q, out_q);
    end
    // A rising edge while reset is held must leave the registers at zero.
    A = 4'd3;
    B = 4'd9;
    @(posedge clk);
    #1;
    checks++;
    if ({co_q, out_q} !== '0) begin
      errors++;
      $display("FAIL reset_hold: {co_q,out_q} got %b_%h expected 0_0", co_q, out_q);
    end
    checks++;
    if ({co, out} !== 5'd12) begin
      errors++;
      $display("FAIL reset_comb: {co,out} got %b_%h expected 0_c", co, out);
    end
    @(negedge clk);
    rst = 1'b0;
    A   = '0;
    B   = '0;
  endtask

  // Directed vectors with hand-computed expectations.
  task automatic test_vectors();
    logic [W-1:0] ta  [6] = '{4'd0, 4'd15, 4'd7, 4'd15, 4'd7, 4'd8};
    logic [W-1:0] tb  [6] = '{4'd0, 4'd1,  4'd1, 4'd15, 4'd8, 4'd8};
    logic         tc  [6] = '{1'b0, 1'b0,  1'b0, 1'b1,  1'b0, 1'b0};
    logic [W-1:0] eo  [6] = '{4'd0, 4'd0,  4'd8, 4'd15, 4'd15, 4'd0};
    logic         eco [6] = '{1'b0, 1'b1,  1'b0, 1'b1,  1'b0, 1'b1};
    logic         eov [6] = '{1'b0, 1'b0,  1'b1, 1'b0,  1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      A  = ta[i];
      B  = tb[i];
      ci = tc[i];
      sb_q.push_back(model_sum(ta[i], tb[i], tc[i]));
      #1;
      checks++;
      if ({co, out} !== {eco[i], eo[i]}) begin
        errors++;
        $display("FAIL vec%0d_sum: A=%0d B=%0d ci=%b {co,out} got %b_%h expected %b_%h",
                 i, ta[i], tb[i], tc[i], co, out, eco[i], eo[i]);
      end
      checks++;
      if (ovf !== eov[i]) begin
        errors++;
        $display("FAIL vec%0d_ovf: A=%0d B=%0d ci=%b ovf got %b expected %b",
                 i, ta[i], tb[i], tc[i], ovf, eov[i]);
      end
      pop_and_check_reg($sformatf("vec%0d_reg", i));
    end
    ci = 1'b0;
  endtask

  // Random operands changed on the falling edge, checked before and after
  // the following rising edge.
  task automatic test_random();
    int   passed = 0;
    int   err0;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      err0 = errors;
      @(negedge clk);
      A  = W'($urandom_range(0, (1 << W) - 1));
      B  = W'($urandom_range(0, (1 << W) - 1));
      ci = 1'b0;
      e  = model_sum(A, B, 1'b0);
      sb_q.push_back(e);
      #1;
      checks++;
      if ({co, out} !== {e.co, e.out}) begin
        errors++;
        $display("FAIL rand%0d_sum: A=%0d B=%0d {co,out} got %b_%h expected %b_%h",
                 i, A, B, co, out, e.co, e.out);
      end
      pop_and_check_reg($sformatf("rand%0d_reg", i));
      if (errors == err0) passed++;
    end
    $display("random: %0d/16 passed", passed);
  endtask

  // Every operand/carry combination on the combinational path.
  task automatic test_exhaustive();
    exp_t e;
    logic eo;
    for (int v = 0; v < (1 << (2*W+1)); v++) begin
      {ci, A, B} = (2*W+1)'(v);
      #1;
      e  = model_sum(A, B, ci);
      eo = model_ovf(A, B, ci);
      checks++;
      if ({co, out, ovf} !== {e.co, e.out, eo}) begin
        errors++;
        $display("FAIL exh: A=%0d B=%0d ci=%b {co,out,ovf} got %b_%h_%b expected %b_%h_%b",
                 A, B, ci, co, out, ovf, e.co, e.out, eo);
      end
    end
  endtask

  // New operands every cycle, with random carry-in, through the register.
  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      A  = W'($urandom);
      B  = W'($urandom);
      ci = 1'($urandom);
      sb_q.push_back(model_sum(A, B, ci));
      pop_and_check_reg($sformatf("b2b%0d_reg", i));
    end
    ci = 1'b0;
  endtask

  // Reset asserted between edges clears the register at once; combinational
  // sum keeps tracking; first edge after release loads the current sum.
  task automatic test_async_reset();
    @(negedge clk);
    A = 4'd4;
    B = 4'd5;
    sb_q.push_back(model_sum(4'd4, 4'd5, 1'b0));
    pop_and_check_reg("ar_load9");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({co_q, out_q} !== '0) begin
      errors++;
      $display("FAIL ar_clear: {co_q,out_q} got %b_%h expected 0_0", co_q, out_q);
    end
    checks++;
    if ({co, out} !== 5'd9) begin
      errors++;
      $display("FAIL ar_comb9: {co,out} got %b_%h expected 0_9", co, out);
    end
    A = 4'd6;
    #1;
    checks++;
    if ({co, out} !== 5'd11) begin
      errors++;
      $display("FAIL ar_comb11: {co,out} got %b_%h expected 0_b", co, out);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(model_sum(4'd6, 4'd5, 1'b0));
    pop_and_check_reg("ar_release");
    // Carry-out register is cleared asynchronously too.
    @(negedge clk);
    A = 4'd15;
    B = 4'd15;
    sb_q.push_back(model_sum(4'd15, 4'd15, 1'b0));
    pop_and_check_reg("ar_load_co");
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({co_q, out_q} !== '0) begin
      errors++;
      $display("FAIL ar_clear_co: {co_q,out_q} got %b_%h expected 0_0", co_q, out_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_exhaustive();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors != 0) $fatal(1, "adder bench detected errors");
    $finish;
  end

endmodule
